dmem_apb_arbiter: RTL and testbench

Shares the single data_memory instance (async read, sync byte-masked write) between the core LSU and an external APB slave port used for debug/DMA loads. The LSU has priority. A starvation counter guarantees APB service by stalling the LSU after STARVE_MAX blocked cycles. The block sits between the MEM stage, the APB interconnect and data_memory.

---
 rtl/dmem_arb_pkg.sv | 5 +
 rtl/dmem_apb_arbiter.sv | 89 ++++++++
 tb/tb_dmem_apb_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory APB arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_e;
  localparam logic [31:0] APB_ERR_RDATA = 32'h0;
endpackage

// File: rtl/dmem_apb_arbiter.sv
// dmem_apb_arbiter: shares data_memory between the LSU (priority) and an APB slave port,
// with a starvation counter that eventually stalls the LSU so APB is always served
module dmem_apb_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DMEM_W     = 11,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_req_i,
  input  logic [DMEM_W-1:0] lsu_addr_i,
  input  logic              lsu_st_en_i,
  input  logic [31:0]       lsu_st_data_i,
  input  logic [3:0]        lsu_mask_i,
  output logic [31:0]       lsu_ld_data_o,
  output logic              lsu_stall_o,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [DMEM_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic [3:0]        pstrb_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [DMEM_W-1:0] mem_addr_o,
  output logic              mem_st_en_o,
  output logic [31:0]       mem_st_data_o,
  output logic [3:0]        mem_mask_o,
  input  logic [31:0]       mem_ld_data_i
);
  localparam int CW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] prdata_q, prdata_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic apb_pend, grant_apb, err, cnt_max;
  always_comb begin
    apb_pend  = psel_i & penable_i & (state_q != RESP);
    cnt_max   = cnt_q == CW'(STARVE_MAX);
    grant_apb = apb_pend & (!lsu_req_i | cnt_max);
    err       = paddr_i[1:0] != 2'b00;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = grant_apb;
    pslverr_d = grant_apb & err;
    prdata_d  = grant_apb ? ((pwrite_i | err) ? APB_ERR_RDATA : mem_ld_data_i) : prdata_q;
    case (state_q)
      IDLE: begin
        state_d = grant_apb ? RESP : apb_pend ? WAIT : IDLE;
        cnt_d   = (apb_pend & !grant_apb & !cnt_max) ? cnt_q + CW'(1) : cnt_q;
      end
      WAIT: begin
        state_d = !psel_i ? IDLE : grant_apb ? RESP : WAIT;
        cnt_d   = !psel_i ? '0 : (grant_apb | cnt_max) ? cnt_q : cnt_q + CW'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end
  // a granted APB cycle owns the memory; the LSU store is dropped and retried later
  assign mem_addr_o    = grant_apb ? paddr_i : lsu_addr_i;
  assign mem_st_en_o   = grant_apb ? (pwrite_i & !err) : (lsu_req_i & lsu_st_en_i);
  assign mem_st_data_o = grant_apb ? pwdata_i : lsu_st_data_i;
  assign mem_mask_o    = grant_apb ? pstrb_i : lsu_mask_i;
  assign lsu_stall_o   = lsu_req_i & grant_apb;
  assign lsu_ld_data_o = mem_ld_data_i;
  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign pslverr_o     = pslverr_q;
endmodule

// File: tb/tb_dmem_apb_arbiter.sv
// tb_dmem_apb_arbiter: directed checks of the arbiter with STARVE_MAX=4 (u0) and STARVE_MAX=0 (u1)
module tb_dmem_apb_arbiter;
  import dmem_arb_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b1;
  logic lsu_req = 0, lsu_st_en = 0, psel = 0, penable = 0, pwrite = 0;
  logic [10:0] lsu_addr = 0, paddr = 0;
  logic [31:0] lsu_st_data = 0, pwdata = 0;
  logic [3:0] lsu_mask = 0, pstrb = 0;
  logic [31:0] ld0, ld1, prdata0, prdata1, mdata0, mdata1, mld0, mld1;
  logic stall0, stall1, pready0, pready1, pslverr0, pslverr1, mst0, mst1;
  logic [10:0] maddr0, maddr1;
  logic [3:0] mmask0, mmask1;
  logic [31:0] mem0 [0:511];
  logic [31:0] mem1 [0:511];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_apb_arbiter #(.DMEM_W(11), .STARVE_MAX(4)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_st_en_i(lsu_st_en),
    .lsu_st_data_i(lsu_st_data), .lsu_mask_i(lsu_mask), .lsu_ld_data_o(ld0), .lsu_stall_o(stall0),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0),
    .mem_addr_o(maddr0), .mem_st_en_o(mst0), .mem_st_data_o(mdata0), .mem_mask_o(mmask0),
    .mem_ld_data_i(mld0));
  dmem_apb_arbiter #(.DMEM_W(11), .STARVE_MAX(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_st_en_i(lsu_st_en),
    .lsu_st_data_i(lsu_st_data), .lsu_mask_i(lsu_mask), .lsu_ld_data_o(ld1), .lsu_stall_o(stall1),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(pslverr1),
    .mem_addr_o(maddr1), .mem_st_en_o(mst1), .mem_st_data_o(mdata1), .mem_mask_o(mmask1),
    .mem_ld_data_i(mld1));
  assign mld0 = mem0[maddr0[10:2]];
  assign mld1 = mem1[maddr1[10:2]];
  always @(posedge clk) begin
    for (int i = 0; i < 512; i++) begin
      if (clr) mem0[i] <= '0;
      else if (mst0 && maddr0[10:2] == i[8:0])
        for (int b = 0; b < 4; b++) if (mmask0[b]) mem0[i][b*8+:8] <= mdata0[b*8+:8];
      if (clr) mem1[i] <= '0;
      else if (mst1 && maddr1[10:2] == i[8:0])
        for (int b = 0; b < 4; b++) if (mmask1[b]) mem1[i][b*8+:8] <= mdata1[b*8+:8];
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apb_xfer(input logic [10:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                          output int acc, output logic [31:0] rd, output logic e, output logic rdy);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    tick;
    penable = 1;
    acc = 1;
    rdy = 0;
    repeat (20) begin
      tick;
      acc++;
      if (pready0) begin
        rdy = 1;
        break;
      end
    end
    rd = prdata0;
    e = pslverr0;
    psel = 0; penable = 0;
  endtask
  task automatic test_reset;
    repeat (2) tick;
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL reset_pready got %b exp 0", pready0); end
    checks++; if (pslverr0 !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b exp 0", pslverr0); end
    checks++; if (prdata0 !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h exp 0", prdata0); end
    rst_n = 1; clr = 0;
    lsu_req = 1; lsu_st_en = 1; lsu_addr = 11'h000; lsu_st_data = 32'h12345678; lsu_mask = 4'hF;
    #1;
    checks++; if (stall0 !== 1'b0 || mst0 !== 1'b1) begin errors++; $display("FAIL lsu_path stall %b st_en %b exp 0 1", stall0, mst0); end
    tick;
    checks++; if (mem0[0] !== 32'h12345678) begin errors++; $display("FAIL lsu_store got %h exp 12345678", mem0[0]); end
    lsu_req = 0; lsu_st_en = 0;
  endtask
  task automatic test_write_read;
    int acc; logic [31:0] rd; logic e, rdy;
    apb_xfer(11'h010, 1, 32'hDEADBEEF, 4'hF, acc, rd, e, rdy);
    checks++; if (!rdy || acc != 2) begin errors++; $display("FAIL wr_latency got %0d exp 2 (ready %b)", acc, rdy); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_pslverr got %b exp 0", e); end
    checks++; if (mem0[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got %h exp deadbeef", mem0[4]); end
    tick;
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL pready_one_cycle got %b exp 0", pready0); end
    apb_xfer(11'h010, 0, 32'h0, 4'h0, acc, rd, e, rdy);
    checks++; if (!rdy || acc != 2) begin errors++; $display("FAIL rd_latency got %0d exp 2 (ready %b)", acc, rdy); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL rd_data got %h/%b exp deadbeef/0", rd, e); end
  endtask
  task automatic test_strobe;
    int acc; logic [31:0] rd; logic e, rdy;
    apb_xfer(11'h010, 1, 32'h00AA0000, 4'b0100, acc, rd, e, rdy);
    checks++; if (!rdy || e !== 1'b0) begin errors++; $display("FAIL strb_resp ready %b err %b exp 1 0", rdy, e); end
    lsu_req = 1; lsu_st_en = 0; lsu_addr = 11'h010;
    #1;
    checks++; if (ld0 !== 32'hDEAABEEF) begin errors++; $display("FAIL strb_lsu_load got %h exp deaabeef", ld0); end
    lsu_req = 0;
    apb_xfer(11'h010, 1, 32'hFFFFFFFF, 4'b0000, acc, rd, e, rdy);
    checks++; if (!rdy || e !== 1'b0) begin errors++; $display("FAIL strb0_resp ready %b err %b exp 1 0", rdy, e); end
    checks++; if (mem0[4] !== 32'hDEAABEEF) begin errors++; $display("FAIL strb0_mem got %h exp deaabeef", mem0[4]); end
  endtask
  task automatic test_err;
    int acc; logic [31:0] rd; logic e, rdy;
    apb_xfer(11'h013, 1, 32'h11111111, 4'hF, acc, rd, e, rdy);
    checks++; if (!rdy || e !== 1'b1) begin errors++; $display("FAIL err_wr ready %b err %b exp 1 1", rdy, e); end
    checks++; if (mem0[4] !== 32'hDEAABEEF) begin errors++; $display("FAIL err_wr_mem got %h exp deaabeef", mem0[4]); end
    apb_xfer(11'h002, 0, 32'h0, 4'h0, acc, rd, e, rdy);
    checks++; if (!rdy || e !== 1'b1) begin errors++; $display("FAIL err_rd ready %b err %b exp 1 1", rdy, e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_data got %h exp 0", rd); end
  endtask
  task automatic test_starve;
    logic [4:0] stalls = '0;
    int kp = -1;
    logic [31:0] rd = '0;
    lsu_req = 1; lsu_st_en = 1; lsu_addr = 11'h040; lsu_mask = 4'hF; lsu_st_data = 32'hA0;
    psel = 1; penable = 0; pwrite = 0; paddr = 11'h010;
    tick;
    penable = 1;
    for (int k = 0; k < 12; k++) begin
      lsu_st_data = 32'hB0 + k;
      #1;
      if (k < 5) stalls[k] = stall0;
      tick;
      if (k == 4) begin
        checks++; if (mem0[16] !== 32'hB3) begin errors++; $display("FAIL stalled_store got %h exp b3", mem0[16]); end
      end
      if (pready0) begin
        kp = k;
        rd = prdata0;
        break;
      end
    end
    psel = 0; penable = 0;
    checks++; if (stalls !== 5'b10000) begin errors++; $display("FAIL starve_stalls got %b exp 10000", stalls); end
    checks++; if (kp != 4) begin errors++; $display("FAIL starve_pready_cycle got %0d exp 4", kp); end
    checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL starve_rdata got %h exp deaabeef", rd); end
    lsu_st_data = 32'hC5;
    #1;
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL resp_no_stall got %b exp 0", stall0); end
    tick;
    checks++; if (mem0[16] !== 32'hC5) begin errors++; $display("FAIL retry_store got %h exp c5", mem0[16]); end
    lsu_req = 0; lsu_st_en = 0;
  endtask
  task automatic test_abort;
    int acc; logic [31:0] rd; logic e, rdy;
    lsu_req = 1; lsu_st_en = 0; lsu_addr = 11'h000;
    psel = 1; penable = 0; pwrite = 1; paddr = 11'h050; pwdata = 32'h77777777; pstrb = 4'hF;
    tick;
    penable = 1;
    repeat (2) tick;
    #2;
    rst_n = 0;
    #1;
    checks++; if (pready0 !== 1'b0 || u0.state_q !== IDLE || u0.cnt_q !== 3'd0) begin errors++; $display("FAIL rst_abort pready %b state %0d cnt %0d exp 0 0 0", pready0, u0.state_q, u0.cnt_q); end
    psel = 0; penable = 0;
    #1;
    rst_n = 1;
    tick;
    checks++; if (mem0[20] !== 32'h0) begin errors++; $display("FAIL rst_abort_mem got %h exp 0", mem0[20]); end
    psel = 1; penable = 0;
    tick;
    penable = 1;
    repeat (2) tick;
    checks++; if (u0.state_q !== WAIT || u0.cnt_q !== 3'd2) begin errors++; $display("FAIL wait_state state %0d cnt %0d exp 1 2", u0.state_q, u0.cnt_q); end
    psel = 0; penable = 0;
    tick;
    checks++; if (u0.state_q !== IDLE || u0.cnt_q !== 3'd0 || pready0 !== 1'b0) begin errors++; $display("FAIL psel_drop state %0d cnt %0d pready %b exp 0 0 0", u0.state_q, u0.cnt_q, pready0); end
    checks++; if (mem0[20] !== 32'h0) begin errors++; $display("FAIL psel_drop_mem got %h exp 0", mem0[20]); end
    lsu_req = 0;
    apb_xfer(11'h010, 0, 32'h0, 4'h0, acc, rd, e, rdy);
    checks++; if (!rdy || acc != 2 || rd !== 32'hDEAABEEF) begin errors++; $display("FAIL restart got lat %0d data %h exp 2 deaabeef", acc, rd); end
  endtask
  task automatic test_starve0;
    rst_n = 0;
    #1;
    rst_n = 1;
    psel = 1; penable = 0; pwrite = 1; paddr = 11'h070; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    lsu_req = 0; lsu_st_en = 1; lsu_addr = 11'h060; lsu_st_data = 32'hCAFEF00D; lsu_mask = 4'hF;
    tick;
    penable = 1; lsu_req = 1;
    #1;
    checks++; if (stall1 !== 1'b1 || maddr1 !== 11'h070 || mst1 !== 1'b1) begin errors++; $display("FAIL s0_grant stall %b addr %h st %b exp 1 070 1", stall1, maddr1, mst1); end
    tick;
    checks++; if (pready1 !== 1'b1) begin errors++; $display("FAIL s0_pready got %b exp 1", pready1); end
    checks++; if (mem1[28] !== 32'h5A5A5A5A || mem1[24] !== 32'h0) begin errors++; $display("FAIL s0_mem apb %h lsu %h exp 5a5a5a5a 0", mem1[28], mem1[24]); end
    psel = 0; penable = 0;
    #1;
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL s0_retry_stall got %b exp 0", stall1); end
    tick;
    checks++; if (mem1[24] !== 32'hCAFEF00D) begin errors++; $display("FAIL s0_retry_store got %h exp cafef00d", mem1[24]); end
    lsu_req = 0; lsu_st_en = 0;
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_strobe;
    test_err;
    test_starve;
    test_abort;
    test_starve0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
